// File: rtl/nios2_sysid_pkg.sv
// Shared definitions for the system-ID boot checker.
//
// Contents:
//   sysid_state_e      - controller states
//   SYSID_ADDR_ID/_TS  - word addresses of the sysid slave
//   ATTEMPT_W          - width of the visible attempt counter
//   attempt_sat_inc()  - saturating increment for the attempt counter
//   state_is_busy()    - busy decode of a state value
package nios2_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    GAP   = 3'd4,
    PASS  = 3'd5,
    FAIL  = 3'd6
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int ATTEMPT_W = 4;
  typedef logic [ATTEMPT_W-1:0] attempt_t;

  // Sticks at all-ones instead of wrapping back to zero.
  function automatic attempt_t attempt_sat_inc(input attempt_t a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic state_is_busy(input sysid_state_e s);
    return !((s == IDLE) || (s == PASS) || (s == FAIL));
  endfunction

endpackage

// File: rtl/nios2_sysid_tick_counter.sv
// Loadable down-counter with a zero flag.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset (count cleared)
//   load_i      - load load_val_i this edge (wins over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement this edge; holds at zero
//   zero_o      - count is zero
module nios2_sysid_tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nios2_sysid_checker.sv
// Boot-time system-ID checker. Reads the sysid slave's ID word (address 0)
// and, optionally, its build timestamp (address 1) over a single-word
// zero-latency Avalon-MM read port, compares them with the expected values
// and reports pass (id_ok) or, after all retries are used, fail.
//
// Ports:
//   clock, reset_n        - system clock; asynchronous active-low reset
//   start                 - one-cycle request, honoured when not busy
//   m_read, m_address     - Avalon read strobe/address (decoded from state)
//   m_waitrequest         - slave stall
//   m_readdata            - read data, valid when m_read && !m_waitrequest
//   busy, done            - check running / check finished
//   id_ok, fail           - result of the last check
//   timeout               - some attempt of this check hit the stall limit
//   attempts              - attempts used in this check (saturates at 15)
//   id_q, ts_q            - last captured ID / timestamp words
module nios2_sysid_checker
  import nios2_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1400042862,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_read,
  output logic        m_address,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        fail,
  output logic        timeout,
  output logic [3:0]  attempts,
  output logic [31:0] id_q,
  output logic [31:0] ts_q
);

  // One counter serves both the retry gap and the read stall limit, so it
  // is sized for the larger of the two.
  localparam int unsigned TICK_MAX = (RETRY_GAP > TIMEOUT) ? RETRY_GAP : TIMEOUT;
  localparam int          TICK_W   = $clog2(TICK_MAX + 1);
  localparam logic [TICK_W-1:0] GAP_LOAD = TICK_W'(RETRY_GAP);
  // Loaded one short: the edge that finds it at zero is the TIMEOUT-th stall.
  localparam logic [TICK_W-1:0] TMO_LOAD = TICK_W'(TIMEOUT - 1);
  // Internal attempt count is one bit wider than the visible one so that
  // MAX_RETRY=15 (16 attempts) still terminates.
  localparam logic [ATTEMPT_W:0] RETRY_LIMIT = (ATTEMPT_W + 1)'(MAX_RETRY);

  sysid_state_e state_q, state_d;

  logic                 pending_q;
  logic                 abort_q;
  logic [ATTEMPT_W:0]   tries_q;
  attempt_t             att_q;
  logic                 busy_q, done_q, ok_q, fail_q, tmo_q;

  logic                 reading;
  logic                 idle_like;
  logic                 ack;
  logic                 stall_abort;
  logic                 match;
  logic                 begin_check;
  logic                 retry;

  logic                 tick_load;
  logic [TICK_W-1:0]    tick_load_val;
  logic                 tick_dec;
  logic                 tick_zero;

  assign reading     = (state_q == RD_ID) || (state_q == RD_TS);
  assign idle_like   = (state_q == IDLE) || (state_q == PASS) || (state_q == FAIL);
  assign ack         = reading && !m_waitrequest;
  assign stall_abort = reading && m_waitrequest && tick_zero;
  // A timed-out attempt never matches, whatever id_q/ts_q still hold.
  assign match       = !abort_q && (id_q == EXPECTED_ID) &&
                       (!CHECK_TS || (ts_q == EXPECTED_TS));
  assign begin_check = idle_like && (start || pending_q);
  assign retry       = (state_q == GAP) && tick_zero;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PASS, FAIL: begin
        if (begin_check) state_d = RD_ID;
      end
      RD_ID: begin
        if (ack)              state_d = CHECK_TS ? RD_TS : CMP;
        else if (stall_abort) state_d = CMP;
      end
      RD_TS: begin
        if (ack || stall_abort) state_d = CMP;
      end
      CMP: begin
        if (match)                     state_d = PASS;
        else if (tries_q <= RETRY_LIMIT) state_d = GAP;
        else                           state_d = FAIL;
      end
      GAP: begin
        if (retry) state_d = RD_ID;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded straight from the state register: no path from
  // readdata/waitrequest, and the address cannot move during a stall.
  always_comb begin
    m_read    = reading;
    m_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // The counter is reloaded on every entry into a timed state.
  always_comb begin
    tick_load     = (state_d != state_q) &&
                    ((state_d == RD_ID) || (state_d == RD_TS) || (state_d == GAP));
    tick_load_val = (state_d == GAP) ? GAP_LOAD : TMO_LOAD;
    tick_dec      = !tick_load && ((state_q == GAP) || (reading && m_waitrequest));
  end

  nios2_sysid_tick_counter #(
    .WIDTH (TICK_W)
  ) u_tick (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (tick_load),
    .load_val_i (tick_load_val),
    .dec_i      (tick_dec),
    .zero_o     (tick_zero)
  );

  // Status and capture registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= AUTO_START;
      abort_q   <= 1'b0;
      tries_q   <= '0;
      att_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      busy_q <= state_is_busy(state_d);

      if (begin_check) begin
        pending_q <= 1'b0;
        abort_q   <= 1'b0;
        done_q    <= 1'b0;
        ok_q      <= 1'b0;
        fail_q    <= 1'b0;
        tmo_q     <= 1'b0;
        tries_q   <= (ATTEMPT_W + 1)'(1);
        att_q     <= attempt_t'(1);
      end

      if (retry) begin
        abort_q <= 1'b0;
        tries_q <= tries_q + 1'b1;
        att_q   <= attempt_sat_inc(att_q);
      end

      if (ack && (state_q == RD_ID)) id_q <= m_readdata;
      if (ack && (state_q == RD_TS)) ts_q <= m_readdata;

      if (stall_abort) begin
        abort_q <= 1'b1;
        tmo_q   <= 1'b1;
      end

      if ((state_q == CMP) && (state_d == PASS)) begin
        done_q <= 1'b1;
        ok_q   <= 1'b1;
      end
      if ((state_q == CMP) && (state_d == FAIL)) begin
        done_q <= 1'b1;
        fail_q <= 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign id_ok    = ok_q;
  assign fail     = fail_q;
  assign timeout  = tmo_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_nios2_sysid_checker.sv
// Bench for nios2_sysid_checker: a configurable zero-latency sysid slave,
// a per-check reference model pushed into a scoreboard at start time, and
// a monitor that compares the result whenever done rises.
module tb_nios2_sysid_checker;

  localparam logic [31:0] EXP_ID    = 32'd0;
  localparam logic [31:0] EXP_TS    = 32'd1400042862;
  localparam bit          CHK_TS    = 1'b1;
  localparam int          MAX_RETRY = 3;
  localparam int          RETRY_GAP = 16;
  localparam int          TIMEOUT   = 64;
  localparam int          FOREVER   = 100000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        m_read;
  logic        m_address;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        busy, done, id_ok, fail, timeout;
  logic [3:0]  attempts;
  logic [31:0] id_q, ts_q;

  nios2_sysid_checker #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .CHECK_TS    (CHK_TS),
    .MAX_RETRY   (MAX_RETRY),
    .RETRY_GAP   (RETRY_GAP),
    .TIMEOUT     (TIMEOUT),
    .AUTO_START  (1'b1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .m_read        (m_read),
    .m_address     (m_address),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .busy          (busy),
    .done          (done),
    .id_ok         (id_ok),
    .fail          (fail),
    .timeout       (timeout),
    .attempts      (attempts),
    .id_q          (id_q),
    .ts_q          (ts_q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave: per-attempt data and stall lengths ----------------
  logic [31:0] cfg_id [16];
  logic [31:0] cfg_ts [16];
  int          cfg_wid[16];
  int          cfg_wts[16];

  logic slave_clr;
  int   n_id;        // ID reads begun since the check started
  logic in_id_prev;
  int   stall;       // consecutive stalled cycles of the current read
  logic cur_id;
  int   idx;
  int   wlim;

  always_comb begin
    cur_id        = m_read && (m_address == 1'b0);
    idx           = (cur_id && !in_id_prev) ? n_id : n_id - 1;
    wlim          = 0;
    m_waitrequest = 1'b0;
    m_readdata    = 32'hA5A5_0000;
    if (idx < 0)  idx = 0;
    if (idx > 15) idx = 15;
    if (m_read) begin
      wlim          = m_address ? cfg_wts[idx] : cfg_wid[idx];
      m_waitrequest = (stall < wlim);
      m_readdata    = m_address ? cfg_ts[idx] : cfg_id[idx];
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_id       <= 0;
      in_id_prev <= 1'b0;
      stall      <= 0;
    end else begin
      if (slave_clr)                n_id <= 0;
      else if (cur_id && !in_id_prev) n_id <= n_id + 1;
      in_id_prev <= cur_id;
      stall      <= (m_read && m_waitrequest) ? stall + 1 : 0;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          done_edge;
    bit          ok;
    bit          fl;
    bit          tmo;
    int          att;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          rdc;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] m_idq = '0;
  logic [31:0] m_tsq = '0;

  // Whole-check outcome from the slave configuration: each read lasts its
  // stall count plus one acknowledge cycle, or is cut off after TIMEOUT
  // stalled cycles; then one compare cycle, then RETRY_GAP+1 cycles of gap.
  function automatic exp_t model(input int entry);
    exp_t e;
    int   t;
    int   rd;
    int   w;
    bit   ab;
    bit   mt;
    t     = entry;
    rd    = 0;
    e.tmo = 1'b0;
    e.ok  = 1'b0;
    e.fl  = 1'b0;
    e.att = 0;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      e.att = k + 1;
      ab    = 1'b0;
      w     = cfg_wid[k];
      if (w >= TIMEOUT) begin t += TIMEOUT; rd += TIMEOUT; ab = 1'b1; end
      else begin t += w + 1; rd += w + 1; m_idq = cfg_id[k]; end
      if (!ab && CHK_TS) begin
        w = cfg_wts[k];
        if (w >= TIMEOUT) begin t += TIMEOUT; rd += TIMEOUT; ab = 1'b1; end
        else begin t += w + 1; rd += w + 1; m_tsq = cfg_ts[k]; end
      end
      if (ab) e.tmo = 1'b1;
      t += 1;
      mt = !ab && (m_idq == EXP_ID) && (!CHK_TS || (m_tsq == EXP_TS));
      if (mt || (k == MAX_RETRY)) begin
        e.ok = mt;
        e.fl = !mt;
        break;
      end
      t += RETRY_GAP + 1;
    end
    if (e.att > 15) e.att = 15;
    e.done_edge = t;
    e.idv       = m_idq;
    e.tsv       = m_tsq;
    e.rdc       = rd;
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic done_prev;
    int   rd_count;
    exp_t e;
    done_prev = 1'b0;
    rd_count  = 0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        done_prev = 1'b0;
        rd_count  = 0;
      end else begin
        if (m_read === 1'b1) rd_count++;
        if (done === 1'b1 && !done_prev) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 with no check outstanding (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            chk("done_edge", cyc, e.done_edge);
            chk("id_ok", id_ok, e.ok);
            chk("fail", fail, e.fl);
            chk("timeout", timeout, e.tmo);
            chk("attempts", attempts, e.att);
            chk("id_q", id_q, e.idv);
            chk("ts_q", ts_q, e.tsv);
            chk("busy_at_done", busy, 0);
            chk("m_read_cycles", rd_count, e.rdc);
          end
          rd_count = 0;
        end
        done_prev = (done === 1'b1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_all(input logic [31:0] idv, input logic [31:0] tsv,
                         input int wid, input int wts);
    for (int a = 0; a < 16; a++) begin
      cfg_id[a]  = idv;
      cfg_ts[a]  = tsv;
      cfg_wid[a] = wid;
      cfg_wts[a] = wts;
    end
  endtask

  // Call at a negedge; returns at the negedge after the RD_ID entry edge.
  task automatic launch();
    sbq.push_back(model(cyc + 1));
    start     = 1'b1;
    slave_clr = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    slave_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_bound: got %0d checks outstanding after %0d cycles, want 0", sbq.size(), n);
      sbq.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    slave_clr = 1'b0;
    set_all(EXP_ID, EXP_TS, 0, 0);
    repeat (3) @(negedge clock);

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id_ok", id_ok, 0);
    chk("rst_fail", fail, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_attempts", attempts, 0);
    chk("rst_id_q", id_q, 0);
    chk("rst_ts_q", ts_q, 0);
    chk("rst_m_read", m_read, 0);

    // Automatic check on reset release, zero-wait good slave.
    sbq.push_back(model(cyc + 1));
    reset_n = 1'b1;
    drain();

    // Wrong ID forever; also the flag clear right after a start from PASS.
    set_all(32'h5, EXP_TS, 0, 0);
    launch();
    chk("clr_done", done, 0);
    chk("clr_id_ok", id_ok, 0);
    chk("clr_busy", busy, 1);
    chk("clr_attempts", attempts, 1);
    drain();

    // Wrong timestamp on the first attempt only.
    set_all(EXP_ID, EXP_TS, 0, 0);
    cfg_ts[0] = 32'h1234_5678;
    launch();
    drain();

    // Slave stalled forever.
    set_all(EXP_ID, EXP_TS, FOREVER, FOREVER);
    launch();
    drain();

    // Short stall on the ID read.
    set_all(EXP_ID, EXP_TS, 3, 0);
    launch();
    drain();

    // Stall boundaries: one short of the limit passes, exactly the limit aborts.
    set_all(EXP_ID, EXP_TS, 0, TIMEOUT - 1);
    launch();
    drain();
    set_all(EXP_ID, EXP_TS, 0, 0);
    cfg_wid[0] = TIMEOUT;
    launch();
    drain();

    // start during RD_TS is ignored and not queued.
    set_all(EXP_ID, EXP_TS, 0, 5);
    launch();
    @(negedge clock);
    chk("rdts_address", m_address, 1);
    chk("rdts_busy", busy, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clock);
    chk("done_held", done, 1);
    chk("no_rerun_busy", busy, 0);

    // Reset while in GAP, then the automatic re-run.
    set_all(32'h5, EXP_TS, 0, 0);
    launch();
    repeat (8) @(negedge clock);
    chk("gap_busy", busy, 1);
    chk("gap_m_read", m_read, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("gaprst_busy", busy, 0);
    chk("gaprst_done", done, 0);
    chk("gaprst_fail", fail, 0);
    chk("gaprst_attempts", attempts, 0);
    chk("gaprst_id_q", id_q, 0);
    chk("gaprst_m_read", m_read, 0);
    sbq.delete();
    m_idq = '0;
    m_tsq = '0;
    @(negedge clock);
    set_all(EXP_ID, EXP_TS, 0, 0);
    sbq.push_back(model(cyc + 1));
    reset_n = 1'b1;
    drain();

    // Randomised slave behaviour.
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < 16; a++) begin
        cfg_id[a]  = ($urandom_range(0, 2) == 0) ? 32'($urandom()) : EXP_ID;
        cfg_ts[a]  = ($urandom_range(0, 2) == 0) ? 32'($urandom()) : EXP_TS;
        cfg_wid[a] = ($urandom_range(0, 7) == 0) ? FOREVER : int'($urandom_range(0, 3));
        cfg_wts[a] = ($urandom_range(0, 7) == 0) ? FOREVER : int'($urandom_range(0, 3));
      end
      launch();
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
